fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Write-side pointer and full-flag controller for the dual-clock FIFO. It runs entirely in the write clock domain. It accepts write requests and drives the memory write address/enable, and it produces the Gray-coded write pointer that is carried into the read domain by the two-flop pointer synchronizer. It consumes the read-domain Gray pointer after that pointer has passed through the same synchronizer into the write domain, and derives `full_o`, `usedw_o` and, optionally, `almost_full_o`.

## Interface
- `AWIDTH`, 3: memory address width; FIFO depth = 2**AWIDTH; pointer width AWVAL = AWIDTH+1.
- `ALMOST_FULL_VALUE`, 2**AWIDTH-2: `usedw_o` threshold for `almost_full_o` (only meaningful with the macro).

Ports:
- `clk_i`  in  1  write-domain clock.
- `aclr_i`  in  1  reset; one clock; asynchronous, active-high.
- `wrreq_i`  in  1  write request, sampled on rising `clk_i`.
- `rd_pntr_gray_sync_i`  in  AWVAL  read pointer in Gray code, already synchronized into `clk_i`.
- `wr_pntr_gray_o`  out  AWVAL  registered Gray write pointer, sent to the read-domain synchronizer.
- `wr_addr_o`  out  AWIDTH  memory write address = binary write pointer[AWIDTH-1:0].
- `wr_en_o`  out  1  memory write enable = `wrreq_i & ~full_o` (combinational).
- `full_o`  out  1  registered full flag.
- `usedw_o`  out  AWVAL  registered occupancy as seen from the write domain, range 0..2**AWIDTH.
- `almost_full_o`  out  1  registered; present only with `FIFO_ALMOST_FULL_EN`.

## Operation
- Internal state: binary write pointer `wr_bin` (AWVAL bits) and registered Gray pointer `wr_gray`.
- Write accepted when `wrreq_i=1` and `full_o=0`. On acceptance, `wr_bin <= wr_bin+1` modulo 2**AWVAL, and `wr_gray <= bin2gray(wr_bin+1)`.
- `wrreq_i` while `full_o=1` is ignored. There is no pointer change and `wr_en_o=0`; overflow is silently dropped and no error flag is raised.
- Full test is on the next Gray pointer: `full_o <= (wr_gray_next == {~rd_sync[AWVAL-1:AWVAL-2], rd_sync[AWVAL-3:0]})`. Here `wr_gray_next` is the post-acceptance value, or the current value if nothing was accepted.
- Occupancy: `usedw_o <= wr_bin_next - gray2bin(rd_pntr_gray_sync_i)`, computed modulo 2**AWVAL. The result is never greater than 2**AWIDTH.
- Wrap-around: the pointer rolls from 2**AWVAL-1 to 0. The Gray sequence stays single-bit-change across the wrap (1000 -> 0000 for AWIDTH=3).
- Simultaneous write and read-pointer update in the same cycle: both are used in the same next-state computation. `full_o` is evaluated against the new `rd_pntr_gray_sync_i` value.

## Timing
- Reset values: `wr_bin=0`, `wr_pntr_gray_o=0`, `wr_addr_o=0`, `full_o=0`, `usedw_o=0`, `almost_full_o=0`.
- Reset asserted mid-operation clears all state immediately (asynchronously). The first write after deassertion goes to address 0.
- Accepted write at edge N: `wr_addr_o`, `wr_pntr_gray_o`, `usedw_o` and `full_o` all reflect it after edge N.
- Back-to-back writes are accepted every cycle until full.
- The last write that fills the FIFO raises `full_o` on that same edge. The following cycle's `wrreq_i` is therefore blocked.
- A read in the other domain is not seen immediately. After `rd_pntr_gray_sync_i` changes, `full_o` clears one `clk_i` edge later. End to end, this is a minimum of 3 write clocks after the read-side pointer changes: 2 synchronizer flops plus 1 flag register. `full_o` is therefore pessimistic and never optimistic.

## Configuration
- `FIFO_ALMOST_FULL_EN` defined:
  - `almost_full_o` port exists.
  - `almost_full_o <= (usedw_next >= ALMOST_FULL_VALUE)`, registered with the same timing as `full_o`.
- Not defined: the port and its logic are absent, and `ALMOST_FULL_VALUE` is unused.

## Structure
- Shared package `fifo_pkg`: functions `bin2gray` and `gray2bin`, parameterized by width. The read-side controller reuses them.
- One sub-module, `gray_cntr`: the binary+Gray pointer register pair with an increment-enable input and asynchronous clear. It is also instantiated by the read-side controller.

## Test plan
AWIDTH=3 throughout.
- Reset: assert `aclr_i` mid-burst -> all outputs 0 at once; after deassertion the first write gives `wr_addr_o=0`.
- Fill: `rd_pntr_gray_sync_i=0`, 8 consecutive writes -> `full_o=1` after the 8th edge, `wr_pntr_gray_o=4'b1100`, `usedw_o=8`.
- Overflow: a 9th write while full -> `wr_en_o=0`; pointer, `usedw_o` and `full_o` unchanged.
- Drain release: from full, set `rd_pntr_gray_sync_i=4'b0001` -> `full_o=0` and `usedw_o=7` one edge later; the next write refills, `full_o=1`.
- Wrap: cycle the read pointer along so 16 writes are accepted -> `wr_pntr_gray_o` goes 1000 -> 0000 with a single bit change; `usedw_o` stays correct across the wrap.
- Macro on, ALMOST_FULL_VALUE=6: the 6th write sets `almost_full_o=1`; it clears once `usedw_o` drops to 5.

Source files
------------

// File: rtl/fifo_pkg.sv
// Pointer-code helpers shared by the write- and read-side FIFO controllers.
// Functions take zero-extended pointers of any width up to PTR_W_MAX bits.
package fifo_pkg;

  localparam int PTR_W_MAX = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros of a narrower pointer leave the low bits unaffected.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side handshake bundle of the dual-clock FIFO.
// almost_full_o exists only when FIFO_ALMOST_FULL_EN is defined.
interface fifo_wr_ctrl_if #(
  parameter int AWIDTH = 3
);
  localparam int AWVAL = AWIDTH + 1;

  logic              wrreq_i;
  logic [AWVAL-1:0]  rd_pntr_gray_sync_i;
  logic [AWVAL-1:0]  wr_pntr_gray_o;
  logic [AWIDTH-1:0] wr_addr_o;
  logic              wr_en_o;
  logic              full_o;
  logic [AWVAL-1:0]  usedw_o;
`ifdef FIFO_ALMOST_FULL_EN
  logic              almost_full_o;
`endif

  modport slave (
    input  wrreq_i, rd_pntr_gray_sync_i,
    output wr_pntr_gray_o, wr_addr_o, wr_en_o, full_o, usedw_o
`ifdef FIFO_ALMOST_FULL_EN
    , almost_full_o
`endif
  );

  modport master (
    output wrreq_i, rd_pntr_gray_sync_i,
    input  wr_pntr_gray_o, wr_addr_o, wr_en_o, full_o, usedw_o
`ifdef FIFO_ALMOST_FULL_EN
    , almost_full_o
`endif
  );

endinterface

// File: rtl/gray_cntr.sv
// Binary + Gray pointer register pair with increment enable and async clear.
// Exposes the next-state values so flag logic can look one edge ahead.
module gray_cntr
  import fifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         aclr_i,
  input  logic         inc_i,
  output logic [W-2:0] addr_o,
  output logic [W-1:0] gray_o,
  output logic [W-1:0] bin_next_o,
  output logic [W-1:0] gray_next_o
);

  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;

  always_comb begin
    bin_d  = inc_i ? bin_q + W'(1) : bin_q;
    gray_d = W'(bin2gray(ptr_t'(bin_d)));
  end

  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign addr_o      = bin_q[W-2:0];
  assign gray_o      = gray_q;
  assign bin_next_o  = bin_d;
  assign gray_next_o = gray_d;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer, full flag and occupancy for the dual-clock FIFO.
// Optional almost_full_o is built when FIFO_ALMOST_FULL_EN is defined.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int AWIDTH = 3
`ifdef FIFO_ALMOST_FULL_EN
  , parameter int ALMOST_FULL_VALUE = 2**AWIDTH - 2
`endif
) (
  input  logic          clk_i,
  input  logic          aclr_i,
  fifo_wr_ctrl_if.slave bus
);

  localparam int AWVAL = AWIDTH + 1;

  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [AWVAL-1:0]  wr_gray;
  logic [AWVAL-1:0]  wr_bin_next;
  logic [AWVAL-1:0]  wr_gray_next;
  logic [AWVAL-1:0]  rd_sync;
  logic [AWVAL-1:0]  rd_bin;
  logic [AWVAL-1:0]  full_gray;
  logic [AWVAL-1:0]  usedw_d, usedw_q;
  logic              full_d, full_q;

  assign wr_en   = bus.wrreq_i & ~full_q;
  assign rd_sync = bus.rd_pntr_gray_sync_i;

  gray_cntr #(.W(AWVAL)) u_wr_ptr (
    .clk_i       (clk_i),
    .aclr_i      (aclr_i),
    .inc_i       (wr_en),
    .addr_o      (wr_addr),
    .gray_o      (wr_gray),
    .bin_next_o  (wr_bin_next),
    .gray_next_o (wr_gray_next)
  );

  // Full when the writer is exactly one lap ahead: Gray top two bits inverted.
  always_comb begin
    rd_bin    = AWVAL'(gray2bin(ptr_t'(rd_sync)));
    full_gray = {~rd_sync[AWVAL-1:AWVAL-2], rd_sync[AWVAL-3:0]};
    full_d    = (wr_gray_next == full_gray);
    usedw_d   = wr_bin_next - rd_bin;
  end

  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      full_q  <= 1'b0;
      usedw_q <= '0;
    end else begin
      full_q  <= full_d;
      usedw_q <= usedw_d;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [AWVAL-1:0] AF_THRESH = AWVAL'(ALMOST_FULL_VALUE);

  logic almost_full_d, almost_full_q;

  assign almost_full_d = (usedw_d >= AF_THRESH);

  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign bus.almost_full_o = almost_full_q;
`endif

  assign bus.wr_pntr_gray_o = wr_gray;
  assign bus.wr_addr_o      = wr_addr;
  assign bus.wr_en_o        = wr_en;
  assign bus.full_o         = full_q;
  assign bus.usedw_o        = usedw_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with AWIDTH=3; the almost-full scenario
// runs only when FIFO_ALMOST_FULL_EN is defined (threshold 6).
module tb_fifo_wr_ctrl;

  localparam int AW = 3;

  logic clk = 1'b0;
  logic aclr;
  int   checks   = 0;
  int   failures = 0;

  fifo_wr_ctrl_if #(.AWIDTH(AW)) bus ();

  fifo_wr_ctrl #(
    .AWIDTH(AW)
`ifdef FIFO_ALMOST_FULL_EN
    , .ALMOST_FULL_VALUE(6)
`endif
  ) dut (
    .clk_i  (clk),
    .aclr_i (aclr),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    aclr = 1'b1;
    bus.wrreq_i = 1'b0;
    bus.rd_pntr_gray_sync_i = 4'b0000;
    tick();
    tick();
    checks++;
    if (bus.wr_pntr_gray_o !== 4'b0000 || bus.wr_addr_o !== 3'd0 ||
        bus.usedw_o !== 4'd0 || bus.full_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got gray=%b addr=%0d usedw=%0d full=%b want all 0",
               bus.wr_pntr_gray_o, bus.wr_addr_o, bus.usedw_o, bus.full_o);
    end
    aclr = 1'b0;
    bus.wrreq_i = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (bus.wr_addr_o !== 3'd3 || bus.usedw_o !== 4'd3) begin
      failures++;
      $display("FAIL reset_burst got addr=%0d usedw=%0d want addr=3 usedw=3",
               bus.wr_addr_o, bus.usedw_o);
    end
    #2 aclr = 1'b1;
    #1;
    checks++;
    if (bus.wr_pntr_gray_o !== 4'b0000 || bus.wr_addr_o !== 3'd0 ||
        bus.usedw_o !== 4'd0 || bus.full_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got gray=%b addr=%0d usedw=%0d full=%b want all 0",
               bus.wr_pntr_gray_o, bus.wr_addr_o, bus.usedw_o, bus.full_o);
    end
    bus.wrreq_i = 1'b0;
    tick();
    aclr = 1'b0;
    bus.wrreq_i = 1'b1;
    #1;
    checks++;
    if (bus.wr_addr_o !== 3'd0 || bus.wr_en_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_write got addr=%0d wr_en=%b want addr=0 wr_en=1",
               bus.wr_addr_o, bus.wr_en_o);
    end
    tick();
    checks++;
    if (bus.wr_addr_o !== 3'd1 || bus.usedw_o !== 4'd1 || bus.wr_pntr_gray_o !== 4'b0001) begin
      failures++;
      $display("FAIL reset_after_write got addr=%0d usedw=%0d gray=%b want 1 1 0001",
               bus.wr_addr_o, bus.usedw_o, bus.wr_pntr_gray_o);
    end
    bus.wrreq_i = 1'b0;
    aclr = 1'b1;
    #2 aclr = 1'b0;
  endtask

  task automatic test_fill;
    bus.rd_pntr_gray_sync_i = 4'b0000;
    bus.wrreq_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (bus.usedw_o !== 4'(i) || bus.full_o !== (i == 8) || bus.wr_addr_o !== 3'(i)) begin
        failures++;
        $display("FAIL fill_%0d got usedw=%0d full=%b addr=%0d want usedw=%0d full=%b addr=%0d",
                 i, bus.usedw_o, bus.full_o, bus.wr_addr_o, i, (i == 8), i % 8);
      end
    end
    checks++;
    if (bus.wr_pntr_gray_o !== 4'b1100) begin
      failures++;
      $display("FAIL fill_gray got %b want 1100", bus.wr_pntr_gray_o);
    end
  endtask

  task automatic test_overflow;
    bus.wrreq_i = 1'b1;
    #1;
    checks++;
    if (bus.wr_en_o !== 1'b0) begin
      failures++;
      $display("FAIL overflow_wr_en got %b want 0", bus.wr_en_o);
    end
    tick();
    checks++;
    if (bus.wr_pntr_gray_o !== 4'b1100 || bus.usedw_o !== 4'd8 ||
        bus.full_o !== 1'b1 || bus.wr_addr_o !== 3'd0) begin
      failures++;
      $display("FAIL overflow_hold got gray=%b usedw=%0d full=%b addr=%0d want 1100 8 1 0",
               bus.wr_pntr_gray_o, bus.usedw_o, bus.full_o, bus.wr_addr_o);
    end
  endtask

  task automatic test_drain_release;
    bus.wrreq_i = 1'b0;
    bus.rd_pntr_gray_sync_i = 4'b0001;
    tick();
    checks++;
    if (bus.full_o !== 1'b0 || bus.usedw_o !== 4'd7) begin
      failures++;
      $display("FAIL drain_release got full=%b usedw=%0d want full=0 usedw=7",
               bus.full_o, bus.usedw_o);
    end
    bus.wrreq_i = 1'b1;
    tick();
    checks++;
    if (bus.full_o !== 1'b1 || bus.usedw_o !== 4'd8 ||
        bus.wr_addr_o !== 3'd1 || bus.wr_pntr_gray_o !== 4'b1101) begin
      failures++;
      $display("FAIL drain_refill got full=%b usedw=%0d addr=%0d gray=%b want 1 8 1 1101",
               bus.full_o, bus.usedw_o, bus.wr_addr_o, bus.wr_pntr_gray_o);
    end
    bus.wrreq_i = 1'b0;
  endtask

  task automatic test_wrap;
    logic [3:0] wb, rb, prev, exp_gray;
    wb = 4'd9;
    rb = 4'd2;
    bus.wrreq_i = 1'b0;
    bus.rd_pntr_gray_sync_i = 4'b0011;
    tick();
    checks++;
    if (bus.full_o !== 1'b0 || bus.usedw_o !== 4'd7) begin
      failures++;
      $display("FAIL wrap_setup got full=%b usedw=%0d want full=0 usedw=7",
               bus.full_o, bus.usedw_o);
    end
    for (int k = 0; k < 10; k++) begin
      prev = bus.wr_pntr_gray_o;
      wb = wb + 4'd1;
      rb = rb + 4'd1;
      bus.rd_pntr_gray_sync_i = rb ^ (rb >> 1);
      bus.wrreq_i = 1'b1;
      tick();
      exp_gray = wb ^ (wb >> 1);
      checks++;
      if (bus.wr_pntr_gray_o !== exp_gray || $countones(prev ^ bus.wr_pntr_gray_o) != 1 ||
          bus.usedw_o !== 4'd7 || bus.full_o !== 1'b0) begin
        failures++;
        $display("FAIL wrap_step%0d got gray=%b prev=%b usedw=%0d full=%b want gray=%b usedw=7 full=0",
                 k, bus.wr_pntr_gray_o, prev, bus.usedw_o, bus.full_o, exp_gray);
      end
      if (wb == 4'd0) begin
        checks++;
        if (prev !== 4'b1000 || bus.wr_pntr_gray_o !== 4'b0000) begin
          failures++;
          $display("FAIL wrap_rollover got %b->%b want 1000->0000", prev, bus.wr_pntr_gray_o);
        end
      end
    end
    bus.wrreq_i = 1'b0;
  endtask

`ifdef FIFO_ALMOST_FULL_EN
  task automatic test_almost_full;
    aclr = 1'b1;
    bus.wrreq_i = 1'b0;
    bus.rd_pntr_gray_sync_i = 4'b0000;
    #2 aclr = 1'b0;
    checks++;
    if (bus.almost_full_o !== 1'b0) begin
      failures++;
      $display("FAIL af_reset got %b want 0", bus.almost_full_o);
    end
    bus.wrreq_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (bus.almost_full_o !== (i >= 6)) begin
        failures++;
        $display("FAIL af_write%0d got %b want %b", i, bus.almost_full_o, (i >= 6));
      end
    end
    bus.wrreq_i = 1'b0;
    bus.rd_pntr_gray_sync_i = 4'b0001;
    tick();
    checks++;
    if (bus.almost_full_o !== 1'b0 || bus.usedw_o !== 4'd5) begin
      failures++;
      $display("FAIL af_clear got af=%b usedw=%0d want af=0 usedw=5",
               bus.almost_full_o, bus.usedw_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_release();
    test_wrap();
`ifdef FIFO_ALMOST_FULL_EN
    test_almost_full();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
